fv_mul_sched: RTL and testbench

Sequencing controller that shares one `multiplier_top` between the two FV public-key polynomials during encryption. It accepts the random polynomial `u` once, buffers it, and replays it against `p0` and then `p1`. It routes the multiplier's result stream to `c0` (pass 0) or `c1` (pass 1). The block sits between the key/noise sources and the single multiplier instance, and drives the downstream ciphertext accumulators.

---
 rtl/fv_enc_pkg.sv | 13 +
 rtl/coef_buf.sv | 31 +++
 rtl/fv_mul_sched.sv | 189 ++++++++++++++++++
 tb/tb_fv_mul_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fv_enc_pkg.sv
// Purpose: shared types and default sizes for the FV encryption datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FV_N / FV_QW / FV_UW defaults and the multiply-scheduler state encoding.
package fv_enc_pkg;

  localparam int FV_N  = 4;  // coefficients per polynomial (power of two, >= 2)
  localparam int FV_QW = 5;  // coefficient width mod q
  localparam int FV_UW = 1;  // width of a u coefficient

  typedef enum logic [1:0] {LOAD_U, PASS0, PASS1, DRAIN} sched_state_e;

endpackage

// File: rtl/coef_buf.sv
// Purpose: N x UW coefficient store holding u while it is replayed twice.
// Latency: write lands on the next clk edge; read is combinational.
// Backpressure: none, the owner gates the write enable.
// Ports: clk; write port we/waddr/wdata; read port raddr -> rdata.
// Contents are deliberately not reset: every entry is rewritten before it is read.
module coef_buf
  import fv_enc_pkg::*;
#(
  parameter int N  = FV_N,
  parameter int UW = FV_UW,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [UW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [UW-1:0] rdata
);

  logic [UW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fv_mul_sched.sv
// Purpose: shares one multiplier between p0*u and p1*u: buffers u, replays it per pass, routes z to c0/c1.
// Latency: 0 cycles p0/p1 -> mp/mu and mz -> c0/c1 (pure combinational routing, no added buffering).
// Backpressure: p0/p1 stall on mp/mu rdy; mz stalls on the selected c0/c1 rdy; u stalls until DRAIN ends.
// Ports: clk, s_rst (sync, active-high); u (UW) in; p0/p1 (QW) in; mp (QW)/mu (UW) out to the multiplier;
//        mz (QW) in from the multiplier; c0/c1 (QW) out; busy; err (sticky framing error).
// Option: define FV_SCHED_FRAMECHK_EN to check every input/mz 'last' against the beat counters;
//         otherwise err is 0 and the 'last' inputs are ignored. Counters always govern sequencing.
module fv_mul_sched
  import fv_enc_pkg::*;
#(
  parameter int N  = FV_N,
  parameter int QW = FV_QW,
  parameter int UW = FV_UW
) (
  input  logic          clk,
  input  logic          s_rst,
  // random polynomial u
  input  logic          u_vld,
  output logic          u_rdy,
  input  logic [UW-1:0] u_dat,
  input  logic          u_last,
  // public key polynomial 0
  input  logic          p0_vld,
  output logic          p0_rdy,
  input  logic [QW-1:0] p0_dat,
  input  logic          p0_last,
  // public key polynomial 1
  input  logic          p1_vld,
  output logic          p1_rdy,
  input  logic [QW-1:0] p1_dat,
  input  logic          p1_last,
  // multiplier p operand
  output logic          mp_vld,
  input  logic          mp_rdy,
  output logic [QW-1:0] mp_dat,
  output logic          mp_last,
  // multiplier u operand
  output logic          mu_vld,
  input  logic          mu_rdy,
  output logic [UW-1:0] mu_dat,
  output logic          mu_last,
  // multiplier result
  input  logic          mz_vld,
  output logic          mz_rdy,
  input  logic [QW-1:0] mz_dat,
  input  logic          mz_last,
  // ciphertext component 0
  output logic          c0_vld,
  input  logic          c0_rdy,
  output logic [QW-1:0] c0_dat,
  output logic          c0_last,
  // ciphertext component 1
  output logic          c1_vld,
  input  logic          c1_rdy,
  output logic [QW-1:0] c1_dat,
  output logic          c1_last,
  // status
  output logic          busy,
  output logic          err
);

  localparam int AW = $clog2(N);

  sched_state_e  state, state_nxt;
  logic [AW-1:0] icnt;
  logic [AW-1:0] zcnt;
  logic [1:0]    zpass;

  logic          icnt_last, zcnt_last;
  logic          in_pass, in_vld, in_fire, u_fire, z_fire, osel;
  logic [QW-1:0] in_dat;

  assign icnt_last = (icnt == AW'(N - 1));
  assign zcnt_last = (zcnt == AW'(N - 1));

  // ---------------- input side ----------------
  assign in_pass = (state == PASS0) || (state == PASS1);
  assign in_vld  = (state == PASS0) ? p0_vld : (state == PASS1) ? p1_vld : 1'b0;
  assign in_dat  = (state == PASS1) ? p1_dat : p0_dat;

  assign u_rdy   = (state == LOAD_U) && !s_rst;
  assign u_fire  = u_vld && u_rdy;

  // p and u operands advance together, so both multiplier ports must be ready.
  assign p0_rdy  = (state == PASS0) && mp_rdy && mu_rdy && !s_rst;
  assign p1_rdy  = (state == PASS1) && mp_rdy && mu_rdy && !s_rst;
  assign in_fire = in_pass && in_vld && mp_rdy && mu_rdy && !s_rst;

  assign mp_vld  = in_vld && !s_rst;
  assign mu_vld  = in_vld && !s_rst;
  assign mp_dat  = in_dat;
  assign mp_last = icnt_last;
  assign mu_last = icnt_last;

  // icnt is the write address while loading and the replay address in both passes.
  coef_buf #(.N(N), .UW(UW), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (u_fire),
    .waddr (icnt),
    .wdata (u_dat),
    .raddr (icnt),
    .rdata (mu_dat)
  );

  // ---------------- output routing ----------------
  // zpass counts completed result polynomials; its LSB picks c0 or c1.
  assign osel    = zpass[0];
  assign c0_vld  = mz_vld && !osel && !s_rst;
  assign c1_vld  = mz_vld &&  osel && !s_rst;
  assign c0_dat  = mz_dat;
  assign c1_dat  = mz_dat;
  assign c0_last = zcnt_last;
  assign c1_last = zcnt_last;
  assign mz_rdy  = (osel ? c1_rdy : c0_rdy) && !s_rst;
  assign z_fire  = mz_vld && mz_rdy;

  assign busy    = (state != LOAD_U) && !s_rst;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state <= LOAD_U;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_U:  if (u_fire && icnt_last)  state_nxt = PASS0;
      PASS0:   if (in_fire && icnt_last) state_nxt = PASS1;
      PASS1:   if (in_fire && icnt_last) state_nxt = DRAIN;
      DRAIN:   if (zpass == 2'd2)        state_nxt = LOAD_U;
      default: state_nxt = LOAD_U;
    endcase
  end

  // ---------------- counters ----------------
  // N is a power of two, so both beat counters wrap on their own.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      icnt <= '0;
    end else if (u_fire || in_fire) begin
      icnt <= icnt + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      zcnt  <= '0;
      zpass <= '0;
    end else begin
      if (z_fire) begin
        zcnt <= zcnt + AW'(1);
      end
      if (state == DRAIN && zpass == 2'd2) begin
        zpass <= '0;
      end else if (z_fire && zcnt_last) begin
        zpass <= zpass + 2'd1;
      end
    end
  end

  // ---------------- framing check ----------------
`ifdef FV_SCHED_FRAMECHK_EN
  logic in_last;
  logic err_q;

  assign in_last = (state == PASS1) ? p1_last : p0_last;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      err_q <= 1'b0;
    end else if ((u_fire  && (u_last  != icnt_last)) ||
                 (in_fire && (in_last != icnt_last)) ||
                 (z_fire  && (mz_last != zcnt_last))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_last;
  assign unused_last = ^{u_last, p0_last, p1_last, mz_last};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fv_mul_sched.sv
// Purpose: directed self-checking bench for fv_mul_sched with a negacyclic multiplier stand-in.
// Latency: stand-in multiplier emits z the cycle after the last operand pair of a pass.
// Backpressure: sink/multiplier ready patterns are scripted per scenario.
module tb_fv_mul_sched;

  localparam int N  = 4;
  localparam int QW = 5;
  localparam int UW = 1;

`ifdef FV_SCHED_FRAMECHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic s_rst;
  logic u_vld, u_rdy, u_last;
  logic [UW-1:0] u_dat;
  logic p0_vld, p0_rdy, p0_last, p1_vld, p1_rdy, p1_last;
  logic [QW-1:0] p0_dat, p1_dat;
  logic mp_vld, mp_rdy, mp_last, mu_vld, mu_rdy, mu_last;
  logic [QW-1:0] mp_dat;
  logic [UW-1:0] mu_dat;
  logic mz_vld, mz_rdy, mz_last;
  logic [QW-1:0] mz_dat;
  logic c0_vld, c0_rdy, c0_last, c1_vld, c1_rdy, c1_last;
  logic [QW-1:0] c0_dat, c1_dat;
  logic busy, err;

  always #5 clk = ~clk;

  fv_mul_sched #(.N(N), .QW(QW), .UW(UW)) dut (
    .clk(clk), .s_rst(s_rst),
    .u_vld(u_vld), .u_rdy(u_rdy), .u_dat(u_dat), .u_last(u_last),
    .p0_vld(p0_vld), .p0_rdy(p0_rdy), .p0_dat(p0_dat), .p0_last(p0_last),
    .p1_vld(p1_vld), .p1_rdy(p1_rdy), .p1_dat(p1_dat), .p1_last(p1_last),
    .mp_vld(mp_vld), .mp_rdy(mp_rdy), .mp_dat(mp_dat), .mp_last(mp_last),
    .mu_vld(mu_vld), .mu_rdy(mu_rdy), .mu_dat(mu_dat), .mu_last(mu_last),
    .mz_vld(mz_vld), .mz_rdy(mz_rdy), .mz_dat(mz_dat), .mz_last(mz_last),
    .c0_vld(c0_vld), .c0_rdy(c0_rdy), .c0_dat(c0_dat), .c0_last(c0_last),
    .c1_vld(c1_vld), .c1_rdy(c1_rdy), .c1_dat(c1_dat), .c1_last(c1_last),
    .busy(busy), .err(err)
  );

  // Hand-computed vectors. *_ONES are p*(1+x+x^2+x^3) mod (x^4+1), mod 32.
  logic [QW-1:0] P0V [N] = '{5'd30, 5'd8, 5'd31, 5'd4};
  logic [QW-1:0] P1V [N] = '{5'd1, 5'd2, 5'd3, 5'd4};
  logic [QW-1:0] P0_ONES [N] = '{5'd19, 5'd3, 5'd1, 5'd9};
  logic [QW-1:0] P1_ONES [N] = '{5'd24, 5'd28, 5'd2, 5'd10};
  logic [UW-1:0] U_IMP [N] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [UW-1:0] U_ONE [N] = '{1'b1, 1'b1, 1'b1, 1'b1};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // sources, sinks, multiplier stand-in
  logic [UW-1:0] uq[$];
  logic [QW-1:0] p0q[$], p1q[$], zq[$], mpb[$], c0g[$], c1g[$];
  logic [UW-1:0] mub[$];
  int u_idx, p0_idx, p1_idx, z_idx;
  int bad_p0_beat, mp_stall_at, mp_stall_left, rst_at_p1;
  bit u_gaps, c0_toggle, rst_req;

  // per-scenario observations
  int cyc, pc, u_beats, p0_beats, p1_beats, z_beats;
  int u4_cyc, p0_first, p0b1_cyc, p0_last_cyc, p1_first, zc8, zlast_cyc;
  logic [7:0] c0lv, c1lv, mplv, mug;
  bit busy_log[512], urdy_log[512], p0rdy_log[512], vld_log[512], rdy_log[512], err_log[512];

  task automatic start_op();
    cyc = 0; pc = 0; u_beats = 0; p0_beats = 0; p1_beats = 0; z_beats = 0;
    u4_cyc = -1; p0_first = -1; p0b1_cyc = -1; p0_last_cyc = -1; p1_first = -1;
    zc8 = -1; zlast_cyc = 0;
    c0lv = '0; c1lv = '0; mplv = '0; mug = '0;
    c0g.delete(); c1g.delete();
    bad_p0_beat = -1; mp_stall_at = -1; mp_stall_left = 0; rst_at_p1 = 0;
    u_gaps = 0; c0_toggle = 0;
  endtask

  task automatic push_op(input bit ones);
    for (int i = 0; i < N; i++) begin
      uq.push_back(ones ? U_ONE[i] : U_IMP[i]);
      p0q.push_back(P0V[i]);
      p1q.push_back(P1V[i]);
    end
  endtask

  task automatic mult_pass();
    for (int k = 0; k < N; k++) begin
      int acc;
      acc = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (i + j == k)          acc += int'(mpb[i]) * int'(mub[j]);
          else if (i + j == k + N) acc -= int'(mpb[i]) * int'(mub[j]);
        end
      zq.push_back(QW'(acc));
    end
    mpb.delete(); mub.delete();
  endtask

  // One clock: drive at posedge+1, sample handshakes at posedge-1, return at posedge+1.
  task automatic cycle();
    s_rst   = rst_req;
    u_vld   = (uq.size() > 0) && !(u_gaps && (cyc % 2 == 1));
    u_dat   = (uq.size() > 0) ? uq[0] : '0;
    u_last  = (u_idx == N - 1);
    p0_vld  = (p0q.size() > 0);
    p0_dat  = (p0q.size() > 0) ? p0q[0] : '0;
    p0_last = (p0_idx == N - 1) ^ (p0_idx == bad_p0_beat);
    p1_vld  = (p1q.size() > 0);
    p1_dat  = (p1q.size() > 0) ? p1q[0] : '0;
    p1_last = (p1_idx == N - 1);
    mp_rdy  = (mp_stall_left == 0);
    mu_rdy  = 1'b1;
    mz_vld  = (zq.size() > 0);
    mz_dat  = (zq.size() > 0) ? zq[0] : '0;
    mz_last = (z_idx == N - 1);
    c0_rdy  = c0_toggle ? (cyc % 2 == 0) : 1'b1;
    c1_rdy  = 1'b1;
    #8;
    if (cyc < 512) begin
      busy_log[cyc]  = busy;
      urdy_log[cyc]  = u_rdy;
      p0rdy_log[cyc] = p0_rdy;
      vld_log[cyc]   = mp_vld | mu_vld | c0_vld | c1_vld;
      rdy_log[cyc]   = p0_rdy | p1_rdy | mz_rdy;
      err_log[cyc]   = err;
    end
    if (u_vld && u_rdy) begin
      void'(uq.pop_front()); u_idx = (u_idx + 1) % N; u_beats++;
      if (u_beats == N) u4_cyc = cyc;
    end
    if (p0_vld && p0_rdy) begin
      void'(p0q.pop_front()); p0_idx = (p0_idx + 1) % N; p0_beats++;
      if (p0_beats == 1) p0_first = cyc;
      if (p0_beats == 2) p0b1_cyc = cyc;
      if (p0_beats == N) p0_last_cyc = cyc;
    end
    if (p1_vld && p1_rdy) begin
      void'(p1q.pop_front()); p1_idx = (p1_idx + 1) % N; p1_beats++;
      if (p1_beats == 1) p1_first = cyc;
    end
    if (mp_vld && mp_rdy && mu_vld && mu_rdy) begin
      if (pc < 8) begin mplv[pc] = mp_last; mug[pc] = mu_dat[0]; end
      pc++;
      mpb.push_back(mp_dat); mub.push_back(mu_dat);
      if (mpb.size() == N) mult_pass();
    end
    if (mz_vld && mz_rdy) begin
      void'(zq.pop_front()); z_idx = (z_idx + 1) % N; z_beats++; zlast_cyc = cyc;
      if (z_beats == 2 * N) zc8 = cyc;
    end
    if (c0_vld && c0_rdy) begin
      if (c0g.size() < 8) c0lv[c0g.size()] = c0_last;
      c0g.push_back(c0_dat);
    end
    if (c1_vld && c1_rdy) begin
      if (c1g.size() < 8) c1lv[c1g.size()] = c1_last;
      c1g.push_back(c1_dat);
    end
    if (s_rst) begin
      uq.delete(); p0q.delete(); p1q.delete(); zq.delete(); mpb.delete(); mub.delete();
      u_idx = 0; p0_idx = 0; p1_idx = 0; z_idx = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    rst_req = 0;
    if (rst_at_p1 > 0 && p1_beats == rst_at_p1) begin
      rst_req = 1; rst_at_p1 = 0;
    end
    if (mp_stall_left > 0) mp_stall_left--;
    if (mp_stall_at >= 0 && p0_beats == mp_stall_at) begin
      mp_stall_left = 3; mp_stall_at = -1;
    end
  endtask

  task automatic run_op(input int nz);
    bit done;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      cycle();
      if (z_beats >= nz && cyc > zlast_cyc + 2) done = 1;
    end
    chk("op_done", done, 1);
  endtask

  task automatic chk_results(input string tag, input int off, input bit ones);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_c0[%0d]", tag, off + i),
          (off + i < c0g.size()) ? 32'(c0g[off + i]) : 32'hFFFF_FFFF,
          32'(ones ? P0_ONES[i] : P0V[i]));
      chk($sformatf("%s_c1[%0d]", tag, off + i),
          (off + i < c1g.size()) ? 32'(c1g[off + i]) : 32'hFFFF_FFFF,
          32'(ones ? P1_ONES[i] : P1V[i]));
    end
  endtask

  initial begin
    u_idx = 0; p0_idx = 0; p1_idx = 0; z_idx = 0;
    rst_req = 0;
    start_op();
    @(posedge clk);
    #1;

    // ---- reset ----
    rst_req = 1; cycle();
    rst_req = 1; cycle();
    chk("rst_vld", vld_log[1], 0);
    chk("rst_rdy", rdy_log[1] | urdy_log[1], 0);
    chk("rst_busy", busy_log[1], 0);

    // ---- basic ----
    start_op(); push_op(0);
    run_op(2 * N);
    chk("basic_urdy0", urdy_log[0], 1);
    chk("basic_busy0", busy_log[0], 0);
    chk("basic_err0", err_log[0], 0);
    chk_results("basic", 0, 0);
    chk("basic_c0_n", c0g.size(), N);
    chk("basic_c1_n", c1g.size(), N);
    chk("basic_c0_last", c0lv[3:0], 4'b1000);
    chk("basic_c1_last", c1lv[3:0], 4'b1000);
    chk("basic_mp_last", mplv, 8'b1000_1000);
    chk("basic_mu_replay", mug, 8'b0001_0001);
    chk("basic_p0_start", p0_first, u4_cyc + 1);
    chk("basic_p1_start", p1_first, p0_last_cyc + 1);
    chk("basic_busy_z8", busy_log[zc8 + 1], 1);
    chk("basic_busy_fall", busy_log[zc8 + 2], 0);

    // ---- back-pressure ----
    start_op(); push_op(0);
    c0_toggle = 1; mp_stall_at = 2;
    run_op(2 * N);
    chk_results("bp", 0, 0);
    chk("bp_c0_n", c0g.size(), N);
    chk("bp_c1_n", c1g.size(), N);
    chk("bp_c0_last", c0lv[3:0], 4'b1000);

    // ---- stall on u ----
    start_op(); push_op(0);
    u_gaps = 1;
    run_op(2 * N);
    begin
      int early;
      early = 0;
      for (int c = 0; c <= u4_cyc && c < 512; c++) early += p0rdy_log[c];
      chk("ustall_p0rdy_early", early, 0);
    end
    chk("ustall_p0rdy_rise", p0rdy_log[u4_cyc + 1], 1);
    chk("ustall_p0_start", p0_first, u4_cyc + 1);
    chk_results("ustall", 0, 0);

    // ---- back-to-back ----
    start_op(); push_op(1); push_op(0);
    run_op(4 * N);
    begin
      int rise;
      rise = -1;
      for (int c = u4_cyc + 1; c < 512 && rise < 0; c++) if (urdy_log[c]) rise = c;
      chk("b2b_urdy_rise", rise, zc8 + 2);
    end
    chk_results("b2b_a", 0, 1);
    chk_results("b2b_b", N, 0);
    chk("b2b_c0_last", c0lv, 8'b1000_1000);

    // ---- reset mid-PASS1 ----
    start_op(); push_op(0);
    rst_at_p1 = 2;
    for (int k = 0; k < 40; k++) cycle();
    begin
      int rc;
      rc = -1;
      for (int c = 0; c < 40 && rc < 0; c++) if (!busy_log[c] && c > p1_first) rc = c;
      chk("mid_rst_found", (rc > 0) ? 1 : 0, 1);
      if (rc > 0) begin
        chk("mid_rst_cyc_vld", vld_log[rc], 0);
        chk("mid_rst_cyc_rdy", rdy_log[rc] | urdy_log[rc], 0);
        chk("mid_rst_next_vld", vld_log[rc + 1], 0);
        chk("mid_rst_next_urdy", urdy_log[rc + 1], 1);
        chk("mid_rst_next_busy", busy_log[rc + 1], 0);
      end
    end
    chk("mid_rst_c0_nolast", c0lv, 8'h00);
    chk("mid_rst_c1_n", c1g.size(), 0);
    start_op(); push_op(0);
    run_op(2 * N);
    chk_results("after_rst", 0, 0);

    // ---- framing: p0 last on beat 1 ----
    start_op(); push_op(0);
    bad_p0_beat = 1;
    run_op(2 * N);
    chk("frame_err_before", err_log[p0b1_cyc], 0);
    chk("frame_err_next", err_log[p0b1_cyc + 1], EXP_ERR);
    chk("frame_err_hold", err_log[cyc - 1], EXP_ERR);
    chk_results("frame", 0, 0);
    start_op();
    rst_req = 1; cycle();
    cycle();
    chk("frame_err_clear", err_log[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
